// File: rtl/hit_response_fsm.sv
// rtl/hit_response_fsm.sv - defender hit detection, damage, knockback, hitstun and invulnerability
module hit_response_fsm #(
    parameter int HB_OFF         = 16,
    parameter int HB_W           = 24,
    parameter int HB_H           = 16,
    parameter int PL_W           = 16,
    parameter int PL_H           = 32,
    parameter int DMG            = 8,
    parameter int KB_BASE        = 4,
    parameter int KB_SHIFT       = 3,
    parameter int HITSTUN_FRAMES = 20,
    parameter int INVULN_FRAMES  = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              atk_active,
    input  logic              atk_facing_right,
    input  logic [9:0]        atk_x,
    input  logic [9:0]        atk_y,
    input  logic [9:0]        def_x,
    input  logic [9:0]        def_y,
    input  logic              damage_clr,
    output logic              hit_pulse,
    output logic              hitstun,
    output logic              invuln,
    output logic [9:0]        damage_pct,
    output logic signed [7:0] kb_vx,
    output logic signed [7:0] kb_vy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HITSTUN = 2'd1,
        INVULN  = 2'd2
    } state_t;

    localparam int TMAX    = (HITSTUN_FRAMES > INVULN_FRAMES) ? HITSTUN_FRAMES : INVULN_FRAMES;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam int HS_LOAD = HITSTUN_FRAMES - 1;
    localparam int IV_LOAD = (INVULN_FRAMES > 0) ? INVULN_FRAMES - 1 : 0;

    // 12-bit signed geometry leaves headroom so right-side bounds near x=1023
    // and left-side bounds below zero never wrap.
    localparam logic signed [11:0] HB_OFF_S = 12'(HB_OFF);
    localparam logic signed [11:0] HB_W_S   = 12'(HB_W);
    localparam logic signed [11:0] HB_H_S   = 12'(HB_H);
    localparam logic signed [11:0] PL_W_S   = 12'(PL_W);
    localparam logic signed [11:0] PL_H_S   = 12'(PL_H);

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic            consumed, consumed_n;
    logic [9:0]      dmg_n;
    logic signed [7:0] vx_n, vy_n;
    logic            pulse_n;

    logic signed [11:0] ax, ay, dx, dy;
    logic signed [11:0] hb_l, hb_r, hb_t, hb_b;
    logic signed [11:0] hu_l, hu_r, hu_t, hu_b;
    logic               overlap, hit;

    logic [9:0]  base;
    logic [10:0] dmg_sum;
    logic [9:0]  dmg_hit;
    logic [10:0] mag_sum;
    logic [6:0]  mag;
    logic signed [7:0] vx_hit, vy_hit;

    // Hitbox/hurtbox bounds and strict interval overlap (touching edges miss).
    always_comb begin
        ax   = $signed({2'b00, atk_x});
        ay   = $signed({2'b00, atk_y});
        dx   = $signed({2'b00, def_x});
        dy   = $signed({2'b00, def_y});
        hb_l = atk_facing_right ? (ax + HB_OFF_S) : (ax - HB_OFF_S - HB_W_S);
        hb_r = hb_l + HB_W_S;
        hb_t = ay;
        hb_b = ay + HB_H_S;
        hu_l = dx;
        hu_r = dx + PL_W_S;
        hu_t = dy;
        hu_b = dy + PL_H_S;
        overlap = (hb_l < hu_r) && (hu_l < hb_r) && (hb_t < hu_b) && (hu_t < hb_b);
        hit     = (state == IDLE) && atk_active && !consumed && overlap;
    end

    // Damage accumulation with saturation and the knockback it implies.
    always_comb begin
        base    = damage_clr ? 10'd0 : damage_pct;
        dmg_sum = {1'b0, base} + 11'(DMG);
        dmg_hit = (dmg_sum > 11'd999) ? 10'd999 : dmg_sum[9:0];
        mag_sum = 11'(KB_BASE) + (11'(dmg_hit) >> KB_SHIFT);
        mag     = (mag_sum > 11'd127) ? 7'd127 : mag_sum[6:0];
        vx_hit  = atk_facing_right ? $signed({1'b0, mag}) : -$signed({1'b0, mag});
        vy_hit  = -$signed({2'b00, mag[6:1]});
    end

    // Next-state, timer, latch-out and damage logic; all advance only on frame_tick.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        consumed_n = consumed;
        dmg_n      = damage_pct;
        vx_n       = kb_vx;
        vy_n       = kb_vy;
        pulse_n    = 1'b0;
        if (frame_tick) begin
            if (!atk_active) begin
                consumed_n = 1'b0;
            end
            dmg_n = base;
            case (state)
                IDLE: begin
                    if (hit) begin
                        state_n    = HITSTUN;
                        timer_n    = TW'(HS_LOAD);
                        pulse_n    = 1'b1;
                        consumed_n = 1'b1;
                        dmg_n      = dmg_hit;
                        vx_n       = vx_hit;
                        vy_n       = vy_hit;
                    end
                end
                HITSTUN: begin
                    if (timer != '0) begin
                        timer_n = timer - 1'b1;
                    end else begin
                        vx_n = '0;
                        vy_n = '0;
                        if (INVULN_FRAMES == 0) begin
                            state_n = IDLE;
                            timer_n = '0;
                        end else begin
                            state_n = INVULN;
                            timer_n = TW'(IV_LOAD);
                        end
                    end
                end
                INVULN: begin
                    if (timer != '0) begin
                        timer_n = timer - 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                    vx_n    = '0;
                    vy_n    = '0;
                end
            endcase
        end
    end

    // State register; hitstun/invuln are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            consumed   <= 1'b0;
            damage_pct <= '0;
            kb_vx      <= '0;
            kb_vy      <= '0;
            hit_pulse  <= 1'b0;
            hitstun    <= 1'b0;
            invuln     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            consumed   <= consumed_n;
            damage_pct <= dmg_n;
            kb_vx      <= vx_n;
            kb_vy      <= vy_n;
            hit_pulse  <= pulse_n;
            hitstun    <= (state_n == HITSTUN);
            invuln     <= (state_n == INVULN);
        end
    end

endmodule

// File: tb/tb_hit_response_fsm.sv
// tb/tb_hit_response_fsm.sv - directed self-checking bench for hit_response_fsm
module tb_hit_response_fsm;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic              atk_active = 1'b0;
    logic              atk_facing_right = 1'b1;
    logic [9:0]        atk_x = 10'd100;
    logic [9:0]        atk_y = 10'd200;
    logic [9:0]        def_x = 10'd120;
    logic [9:0]        def_y = 10'd195;
    logic              damage_clr = 1'b0;
    logic              hit_pulse;
    logic              hitstun;
    logic              invuln;
    logic [9:0]        damage_pct;
    logic signed [7:0] kb_vx;
    logic signed [7:0] kb_vy;

    int passes = 0;
    int total  = 0;
    int pulses;

    hit_response_fsm dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .atk_active       (atk_active),
        .atk_facing_right (atk_facing_right),
        .atk_x            (atk_x),
        .atk_y            (atk_y),
        .def_x            (def_x),
        .def_y            (def_y),
        .damage_clr       (damage_clr),
        .hit_pulse        (hit_pulse),
        .hitstun          (hitstun),
        .invuln           (invuln),
        .damage_pct       (damage_pct),
        .kb_vx            (kb_vx),
        .kb_vy            (kb_vy)
    );

    always #5 clk = ~clk;

    task automatic step(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        atk_active = 1'b0;
        damage_clr = 1'b0;
        step(1'b0);
        reset = 1'b0;
    endtask

    task automatic do_hit();
        atk_active = 1'b1;
        step(1'b1);
        atk_active = 1'b0;
        repeat (50) step(1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pulse", int'(hit_pulse), 0);
        chk("rst_hitstun", int'(hitstun), 0);
        chk("rst_invuln", int'(invuln), 0);
        chk("rst_damage", int'(damage_pct), 0);
        chk("rst_vx", int'(kb_vx), 0);
        chk("rst_vy", int'(kb_vy), 0);

        // Right-facing hit and full hitstun/invuln timeline
        atk_x = 100; atk_y = 200; def_x = 120; def_y = 195; atk_facing_right = 1'b1;
        step(1'b1);
        chk("idle_nohit", int'(hit_pulse), 0);
        atk_active = 1'b1;
        step(1'b1);
        chk("r_pulse", int'(hit_pulse), 1);
        chk("r_hitstun", int'(hitstun), 1);
        chk("r_damage", int'(damage_pct), 8);
        chk("r_vx", int'(kb_vx), 5);
        chk("r_vy", int'(kb_vy), -2);
        atk_active = 1'b0;
        step(1'b0);
        chk("r_pulse_drop", int'(hit_pulse), 0);
        chk("r_hitstun_hold", int'(hitstun), 1);
        for (int i = 1; i <= 19; i++) begin
            step(1'b1);
            chk($sformatf("r_hs_tick%0d", i), int'(hitstun), 1);
        end
        chk("r_vx_held", int'(kb_vx), 5);
        step(1'b1);
        chk("r_hs_end", int'(hitstun), 0);
        chk("r_iv_start", int'(invuln), 1);
        chk("r_vx_zero", int'(kb_vx), 0);
        chk("r_vy_zero", int'(kb_vy), 0);
        for (int i = 1; i <= 29; i++) begin
            step(1'b1);
            chk($sformatf("r_iv_tick%0d", i), int'(invuln), 1);
        end
        step(1'b1);
        chk("r_iv_end", int'(invuln), 0);
        chk("r_idle_hs", int'(hitstun), 0);
        chk("r_damage_kept", int'(damage_pct), 8);

        // Left-facing hitbox side
        do_reset();
        atk_facing_right = 1'b0; def_x = 120;
        atk_active = 1'b1;
        step(1'b1);
        chk("l_miss_pulse", int'(hit_pulse), 0);
        chk("l_miss_dmg", int'(damage_pct), 0);
        def_x = 64;
        step(1'b1);
        chk("l_pulse", int'(hit_pulse), 1);
        chk("l_damage", int'(damage_pct), 8);
        chk("l_vx", int'(kb_vx), -5);
        chk("l_vy", int'(kb_vy), -2);

        // Held attack hits once; re-raise after IDLE hits again
        do_reset();
        atk_facing_right = 1'b1; def_x = 120;
        atk_active = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1);
            if (hit_pulse) pulses++;
        end
        chk("held_pulses", pulses, 1);
        chk("held_damage", int'(damage_pct), 8);
        chk("held_idle", int'(hitstun | invuln), 0);
        atk_active = 1'b0;
        step(1'b1);
        atk_active = 1'b1;
        step(1'b1);
        chk("rehit_pulse", int'(hit_pulse), 1);
        chk("rehit_damage", int'(damage_pct), 16);
        chk("rehit_vx", int'(kb_vx), 6);

        // Edges: negative left-side bounds, touching edges, clear+hit
        do_reset();
        atk_x = 10; atk_facing_right = 1'b0; def_x = 0;
        atk_active = 1'b1;
        step(1'b1);
        chk("neg_nohit", int'(hit_pulse), 0);
        atk_x = 100; atk_facing_right = 1'b1; def_x = 140;
        step(1'b1);
        chk("touch_nohit", int'(hit_pulse), 0);
        chk("touch_dmg", int'(damage_pct), 0);
        def_x = 139;
        step(1'b1);
        chk("overlap1_hit", int'(hit_pulse), 1);
        chk("overlap1_dmg", int'(damage_pct), 8);
        atk_active = 1'b0;
        repeat (50) step(1'b1);
        damage_clr = 1'b1;
        atk_active = 1'b1;
        step(1'b1);
        damage_clr = 1'b0;
        chk("clr_hit_pulse", int'(hit_pulse), 1);
        chk("clr_hit_dmg", int'(damage_pct), 8);
        atk_active = 1'b0;
        repeat (50) step(1'b1);
        damage_clr = 1'b1;
        step(1'b0);
        chk("clr_needs_tick", int'(damage_pct), 8);
        step(1'b1);
        damage_clr = 1'b0;
        chk("clr_only_dmg", int'(damage_pct), 0);

        // Reset during HITSTUN aborts; next attack hits normally
        do_reset();
        def_x = 120;
        atk_active = 1'b1;
        step(1'b1);
        chk("mid_hitstun", int'(hitstun), 1);
        atk_active = 1'b0;
        repeat (5) step(1'b1);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        chk("mid_rst_hs", int'(hitstun), 0);
        chk("mid_rst_iv", int'(invuln), 0);
        chk("mid_rst_dmg", int'(damage_pct), 0);
        chk("mid_rst_vx", int'(kb_vx), 0);
        chk("mid_rst_vy", int'(kb_vy), 0);
        chk("mid_rst_pulse", int'(hit_pulse), 0);
        atk_active = 1'b1;
        step(1'b1);
        chk("post_rst_pulse", int'(hit_pulse), 1);
        chk("post_rst_dmg", int'(damage_pct), 8);

        // Saturation at 999 and knockback clamp at 127
        do_reset();
        repeat (124) do_hit();
        chk("sat_pre_dmg", int'(damage_pct), 992);
        atk_active = 1'b1;
        step(1'b1);
        chk("sat_dmg", int'(damage_pct), 999);
        chk("sat_vx", int'(kb_vx), 127);
        chk("sat_vy", int'(kb_vy), -63);
        atk_active = 1'b0;
        repeat (50) step(1'b1);
        atk_active = 1'b1;
        step(1'b1);
        chk("sat_again_pulse", int'(hit_pulse), 1);
        chk("sat_again_dmg", int'(damage_pct), 999);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
